io_channel_port: RTL and testbench

//  Host-side end of the machine's in/out channels. The host (bench, UART bridge)

---
 rtl/io_channel_port.sv | 228 ++++++++++++++++++++++
 tb/tb_io_channel_port.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_channel_port.sv
// io_channel_port: host-side end of the machine's in/out channels.
// Input FIFO fed by the host and drained by a one-request/one-response read FSM;
// output FIFO fed by the machine and drained by the host through a registered head.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for inReq; a request pops the head (if any) into inData
// RESP  | inAck high for this single cycle, then back to IDLE
module io_channel_port #(
    parameter int MemoryElementWidth = 12,
    parameter int NIn                = 3,
    parameter int NOut               = 6
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    input  logic                          hostInValid,
    input  logic [MemoryElementWidth-1:0] hostInData,
    output logic                          hostInReady,
    output logic [MemoryElementWidth-1:0] inSize,
    input  logic                          inReq,
    output logic                          inAck,
    output logic                          inHit,
    output logic [MemoryElementWidth-1:0] inData,
    input  logic                          outValid,
    input  logic [MemoryElementWidth-1:0] outData,
    output logic                          outReady,
    output logic [MemoryElementWidth-1:0] outCount,
    output logic                          hostOutValid,
    output logic [MemoryElementWidth-1:0] hostOutData,
    input  logic                          hostOutReady
);

    localparam int W   = MemoryElementWidth;
    localparam int IPW = (NIn  > 1) ? $clog2(NIn)  : 1;
    localparam int OPW = (NOut > 1) ? $clog2(NOut) : 1;

    localparam logic [IPW-1:0] IN_LAST  = IPW'(NIn - 1);
    localparam logic [OPW-1:0] OUT_LAST = OPW'(NOut - 1);
    localparam logic [W-1:0]   IN_FULL  = W'(NIn);
    localparam logic [W-1:0]   OUT_FULL = W'(NOut);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } rd_state_t;

    // ------------------------------------------------------------------
    // Input channel
    // ------------------------------------------------------------------
    logic [W-1:0]   in_mem [NIn];
    logic [IPW-1:0] in_wr_ptr;
    logic [IPW-1:0] in_rd_ptr;
    logic [W-1:0]   in_count;
    logic [W-1:0]   in_data_q;
    logic           in_hit_q;
    logic           in_push;
    logic           in_pop;
    logic           req_accept;
    rd_state_t      state;
    rd_state_t      state_next;

    function automatic logic [IPW-1:0] in_inc(input logic [IPW-1:0] p);
        return (p == IN_LAST) ? '0 : p + IPW'(1);
    endfunction

    function automatic logic [OPW-1:0] out_inc(input logic [OPW-1:0] p);
        return (p == OUT_LAST) ? '0 : p + OPW'(1);
    endfunction

    // No pass-through: readiness depends only on the current fill level.
    assign hostInReady = (in_count != IN_FULL);
    assign in_push     = hostInValid && hostInReady && !clear;
    assign inSize      = in_count;
    assign inAck       = (state == ST_RESP);
    assign inHit       = in_hit_q;
    assign inData      = in_data_q;

    // Read FSM next state; clear forces IDLE and suppresses the pop.
    always_comb begin
        state_next = state;
        req_accept = 1'b0;
        in_pop     = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (inReq) begin
                    state_next = ST_RESP;
                    req_accept = 1'b1;
                    in_pop     = (in_count != '0);
                end
            end
            ST_RESP: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (clear) begin
            state_next = ST_IDLE;
            req_accept = 1'b0;
            in_pop     = 1'b0;
        end
    end

    // Read FSM state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Delivered word and hit flag; inData holds across a miss.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_data_q <= '0;
            in_hit_q  <= 1'b0;
        end else if (req_accept) begin
            in_hit_q <= in_pop;
            if (in_pop) begin
                in_data_q <= in_mem[in_rd_ptr];
            end
        end
    end

    // Input storage is not reset; only pointers and count define validity.
    always_ff @(posedge clock) begin
        if (in_push) begin
            in_mem[in_wr_ptr] <= hostInData;
        end
    end

    // Input pointers and fill count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_count  <= '0;
        end else if (clear) begin
            in_wr_ptr <= '0;
            in_rd_ptr <= '0;
            in_count  <= '0;
        end else begin
            if (in_push) begin
                in_wr_ptr <= in_inc(in_wr_ptr);
            end
            if (in_pop) begin
                in_rd_ptr <= in_inc(in_rd_ptr);
            end
            if (in_push && !in_pop) begin
                in_count <= in_count + W'(1);
            end else if (!in_push && in_pop) begin
                in_count <= in_count - W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output channel
    // ------------------------------------------------------------------
    logic [W-1:0]   out_mem [NOut];
    logic [OPW-1:0] out_wr_ptr;
    logic [OPW-1:0] out_rd_ptr;
    logic [OPW-1:0] out_rd_next;
    logic [W-1:0]   out_count;
    logic [W-1:0]   out_remaining;
    logic [W-1:0]   out_head;
    logic           out_push;
    logic           out_pop;

    assign outReady      = (out_count != OUT_FULL);
    assign hostOutValid  = (out_count != '0);
    assign hostOutData   = out_head;
    assign outCount      = out_count;
    assign out_push      = outValid && outReady && !clear;
    assign out_pop       = hostOutValid && hostOutReady && !clear;
    assign out_rd_next   = out_pop ? out_inc(out_rd_ptr) : out_rd_ptr;
    assign out_remaining = out_count - W'(out_pop);

    // Output storage is not reset.
    always_ff @(posedge clock) begin
        if (out_push) begin
            out_mem[out_wr_ptr] <= outData;
        end
    end

    // Output pointers and fill count.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
        end else if (clear) begin
            out_wr_ptr <= '0;
            out_rd_ptr <= '0;
            out_count  <= '0;
        end else begin
            if (out_push) begin
                out_wr_ptr <= out_inc(out_wr_ptr);
            end
            out_rd_ptr <= out_rd_next;
            if (out_push && !out_pop) begin
                out_count <= out_count + W'(1);
            end else if (!out_push && out_pop) begin
                out_count <= out_count - W'(1);
            end
        end
    end

    // Registered head: when the FIFO would otherwise be empty the incoming word
    // becomes the head directly, else the next stored entry is loaded.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_head <= '0;
        end else if (!clear) begin
            if (out_remaining == '0) begin
                if (out_push) begin
                    out_head <= outData;
                end
            end else begin
                out_head <= out_mem[out_rd_next];
            end
        end
    end

endmodule

// File: tb/tb_io_channel_port.sv
// Testbench for io_channel_port: directed vector table, hand sequences for
// clear/reset corner cases, and random traffic against a queue-based model.
module tb_io_channel_port;

    localparam int W  = 12;
    localparam int NI = 3;
    localparam int NO = 6;

    logic         clock;
    logic         reset;
    logic         clear;
    logic         hostInValid;
    logic [W-1:0] hostInData;
    logic         hostInReady;
    logic [W-1:0] inSize;
    logic         inReq;
    logic         inAck;
    logic         inHit;
    logic [W-1:0] inData;
    logic         outValid;
    logic [W-1:0] outData;
    logic         outReady;
    logic [W-1:0] outCount;
    logic         hostOutValid;
    logic [W-1:0] hostOutData;
    logic         hostOutReady;

    io_channel_port #(
        .MemoryElementWidth(W),
        .NIn(NI),
        .NOut(NO)
    ) dut (
        .clock(clock),
        .reset(reset),
        .clear(clear),
        .hostInValid(hostInValid),
        .hostInData(hostInData),
        .hostInReady(hostInReady),
        .inSize(inSize),
        .inReq(inReq),
        .inAck(inAck),
        .inHit(inHit),
        .inData(inData),
        .outValid(outValid),
        .outData(outData),
        .outReady(outReady),
        .outCount(outCount),
        .hostOutValid(hostOutValid),
        .hostOutData(hostOutData),
        .hostOutReady(hostOutReady)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks_total  = 0;
    int checks_passed = 0;

    task automatic check(input string name, input int act, input int exp);
        checks_total++;
        if (act == exp) checks_passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Behavioural model: two queues plus the last delivered word/hit and a
    // pending-acknowledge flag.
    int in_q[$];
    int out_q[$];
    int m_data;
    int m_hit;
    int m_ack;

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        m_data = 0;
        m_hit  = 0;
        m_ack  = 0;
    endtask

    task automatic model_step();
        bit in_rdy;
        bit o_rdy;
        bit o_vld;
        int dummy;
        if (clear) begin
            in_q.delete();
            out_q.delete();
            m_ack = 0;
        end else begin
            in_rdy = (in_q.size() != NI);
            o_rdy  = (out_q.size() != NO);
            o_vld  = (out_q.size() != 0);
            if (m_ack != 0) begin
                m_ack = 0;
            end else if (inReq) begin
                m_ack = 1;
                if (in_q.size() != 0) begin
                    m_data = in_q.pop_front();
                    m_hit  = 1;
                end else begin
                    m_hit = 0;
                end
            end
            if (hostInValid && in_rdy) in_q.push_back(int'(hostInData));
            if (o_vld && hostOutReady) dummy = out_q.pop_front();
            if (outValid && o_rdy) out_q.push_back(int'(outData));
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input bit hiv, input int hid, input bit req, input bit ov,
                         input int od, input bit hor, input bit clr);
        hostInValid  = hiv;
        hostInData   = W'(hid);
        inReq        = req;
        outValid     = ov;
        outData      = W'(od);
        hostOutReady = hor;
        clear        = clr;
    endtask

    task automatic check_model(input string tag);
        check({tag, " hostInReady"}, int'(hostInReady), int'(in_q.size() != NI));
        check({tag, " inSize"}, int'(inSize), in_q.size());
        check({tag, " inAck"}, int'(inAck), m_ack);
        check({tag, " inHit"}, int'(inHit), m_hit);
        check({tag, " inData"}, int'(inData), m_data);
        check({tag, " outReady"}, int'(outReady), int'(out_q.size() != NO));
        check({tag, " outCount"}, int'(outCount), out_q.size());
        check({tag, " hostOutValid"}, int'(hostOutValid), int'(out_q.size() != 0));
        if (out_q.size() != 0) check({tag, " hostOutData"}, int'(hostOutData), out_q[0]);
    endtask

    typedef struct {
        bit hiv; int hid; bit req; bit ov; int od; bit hor; bit clr;
        int e_size; bit e_ack; bit e_hit; int e_data; int e_oc; int e_hod;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input bit hiv, input int hid, input bit req, input bit ov,
                                input int od, input bit hor, input bit clr,
                                input int e_size, input bit e_ack, input bit e_hit,
                                input int e_data, input int e_oc, input int e_hod);
        vec_t v;
        v.hiv = hiv; v.hid = hid; v.req = req; v.ov = ov; v.od = od; v.hor = hor; v.clr = clr;
        v.e_size = e_size; v.e_ack = e_ack; v.e_hit = e_hit; v.e_data = e_data;
        v.e_oc = e_oc; v.e_hod = e_hod;
        vecs.push_back(v);
    endfunction

    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        check("reset hostInReady", int'(hostInReady), 1);
        check("reset inSize", int'(inSize), 0);
        check("reset inAck", int'(inAck), 0);
        check("reset outReady", int'(outReady), 1);
        check("reset hostOutValid", int'(hostOutValid), 0);
        check("reset hostOutData", int'(hostOutData), 0);
        reset = 1'b1;

        //   hiv hid req ov od hor clr | size ack hit data oc hod
        add(0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 0,  0, 0);
        // fill input FIFO, fourth push refused
        add(1, 33, 0, 0, 0,  0, 0,  1, 0, 0, 0,  0, 0);
        add(1, 22, 0, 0, 0,  0, 0,  2, 0, 0, 0,  0, 0);
        add(1, 11, 0, 0, 0,  0, 0,  3, 0, 0, 0,  0, 0);
        add(1, 44, 0, 0, 0,  0, 0,  3, 0, 0, 0,  0, 0);
        // three reads
        add(0, 0,  1, 0, 0,  0, 0,  2, 1, 1, 33, 0, 0);
        add(0, 0,  0, 0, 0,  0, 0,  2, 0, 1, 33, 0, 0);
        add(0, 0,  1, 0, 0,  0, 0,  1, 1, 1, 22, 0, 0);
        add(0, 0,  0, 0, 0,  0, 0,  1, 0, 1, 22, 0, 0);
        add(0, 0,  1, 0, 0,  0, 0,  0, 1, 1, 11, 0, 0);
        add(0, 0,  0, 0, 0,  0, 0,  0, 0, 1, 11, 0, 0);
        // read on empty
        add(0, 0,  1, 0, 0,  0, 0,  0, 1, 0, 11, 0, 0);
        add(0, 0,  0, 0, 0,  0, 0,  0, 0, 0, 11, 0, 0);
        // output fill with host stalled, seventh push refused
        add(0, 0,  0, 1, 3,  0, 0,  0, 0, 0, 11, 1, 3);
        add(0, 0,  0, 1, 33, 0, 0,  0, 0, 0, 11, 2, 3);
        add(0, 0,  0, 1, 2,  0, 0,  0, 0, 0, 11, 3, 3);
        add(0, 0,  0, 1, 22, 0, 0,  0, 0, 0, 11, 4, 3);
        add(0, 0,  0, 1, 1,  0, 0,  0, 0, 0, 11, 5, 3);
        add(0, 0,  0, 1, 11, 0, 0,  0, 0, 0, 11, 6, 3);
        add(0, 0,  0, 1, 99, 0, 0,  0, 0, 0, 11, 6, 3);
        // drain
        add(0, 0,  0, 0, 0,  1, 0,  0, 0, 0, 11, 5, 33);
        add(0, 0,  0, 0, 0,  1, 0,  0, 0, 0, 11, 4, 2);
        add(0, 0,  0, 0, 0,  1, 0,  0, 0, 0, 11, 3, 22);
        add(0, 0,  0, 0, 0,  1, 0,  0, 0, 0, 11, 2, 1);
        add(0, 0,  0, 0, 0,  1, 0,  0, 0, 0, 11, 1, 11);
        add(0, 0,  0, 0, 0,  1, 0,  0, 0, 0, 11, 0, 0);
        // output push on empty with host ready, then push+pop
        add(0, 0,  0, 1, 7,  1, 0,  0, 0, 0, 11, 1, 7);
        add(0, 0,  0, 1, 8,  1, 0,  0, 0, 0, 11, 1, 8);
        add(0, 0,  0, 0, 0,  1, 0,  0, 0, 0, 11, 0, 0);
        // push and read in the same cycle at two entries
        add(1, 5,  0, 0, 0,  0, 0,  1, 0, 0, 11, 0, 0);
        add(1, 6,  0, 0, 0,  0, 0,  2, 0, 0, 11, 0, 0);
        add(1, 7,  1, 0, 0,  0, 0,  2, 1, 1, 5,  0, 0);
        add(0, 0,  0, 0, 0,  0, 0,  2, 0, 1, 5,  0, 0);
        add(0, 0,  1, 0, 0,  0, 0,  1, 1, 1, 6,  0, 0);
        add(0, 0,  0, 0, 0,  0, 0,  1, 0, 1, 6,  0, 0);
        add(0, 0,  1, 0, 0,  0, 0,  0, 1, 1, 7,  0, 0);
        add(0, 0,  0, 0, 0,  0, 0,  0, 0, 1, 7,  0, 0);
        // read on empty does not take the word pushed that cycle
        add(1, 9,  1, 0, 0,  0, 0,  1, 1, 0, 7,  0, 0);
        add(0, 0,  0, 0, 0,  0, 0,  1, 0, 0, 7,  0, 0);
        add(0, 0,  1, 0, 0,  0, 0,  0, 1, 1, 9,  0, 0);
        add(0, 0,  0, 0, 0,  0, 0,  0, 0, 1, 9,  0, 0);
        // request during RESP is ignored
        add(1, 4,  0, 0, 0,  0, 0,  1, 0, 1, 9,  0, 0);
        add(1, 2,  0, 0, 0,  0, 0,  2, 0, 1, 9,  0, 0);
        add(0, 0,  1, 0, 0,  0, 0,  1, 1, 1, 4,  0, 0);
        add(0, 0,  1, 0, 0,  0, 0,  1, 0, 1, 4,  0, 0);
        add(0, 0,  0, 0, 0,  0, 0,  1, 0, 1, 4,  0, 0);
        add(0, 0,  1, 0, 0,  0, 0,  0, 1, 1, 2,  0, 0);
        add(0, 0,  0, 0, 0,  0, 0,  0, 0, 1, 2,  0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].hiv, vecs[i].hid, vecs[i].req, vecs[i].ov, vecs[i].od,
                  vecs[i].hor, vecs[i].clr);
            cycle();
            check({tag, " inSize"}, int'(inSize), vecs[i].e_size);
            check({tag, " hostInReady"}, int'(hostInReady), int'(vecs[i].e_size != NI));
            check({tag, " inAck"}, int'(inAck), int'(vecs[i].e_ack));
            check({tag, " inHit"}, int'(inHit), int'(vecs[i].e_hit));
            check({tag, " inData"}, int'(inData), vecs[i].e_data);
            check({tag, " outCount"}, int'(outCount), vecs[i].e_oc);
            check({tag, " outReady"}, int'(outReady), int'(vecs[i].e_oc != NO));
            check({tag, " hostOutValid"}, int'(hostOutValid), int'(vecs[i].e_oc != 0));
            if (vecs[i].e_oc != 0) check({tag, " hostOutData"}, int'(hostOutData), vecs[i].e_hod);
        end

        // clear with a same-cycle request and pushes: nothing happens but the flush
        drive(1, 8, 0, 1, 8, 0, 0);
        cycle();
        drive(1, 9, 1, 1, 9, 1, 1);
        cycle();
        check("clr_req inAck", int'(inAck), 0);
        check("clr_req inSize", int'(inSize), 0);
        check("clr_req inData", int'(inData), 2);
        check("clr_req outCount", int'(outCount), 0);
        check_model("clr_req");
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        check("clr_req after inAck", int'(inAck), 0);
        // clear during RESP
        drive(1, 3, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 6, 1, 0, 0, 0, 0);
        cycle();
        check("clr_resp pre inAck", int'(inAck), 1);
        drive(1, 7, 0, 0, 0, 0, 1);
        cycle();
        check("clr_resp inAck", int'(inAck), 0);
        check("clr_resp inSize", int'(inSize), 0);
        check_model("clr_resp");

        // asynchronous reset while a response is pending
        drive(1, 1, 0, 1, 5, 0, 0);
        cycle();
        drive(1, 2, 1, 1, 6, 0, 0);
        cycle();
        check("arst pre inAck", int'(inAck), 1);
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b0;
        #1;
        check("arst inAck", int'(inAck), 0);
        check("arst inHit", int'(inHit), 0);
        check("arst inData", int'(inData), 0);
        check("arst inSize", int'(inSize), 0);
        check("arst hostInReady", int'(hostInReady), 1);
        check("arst outCount", int'(outCount), 0);
        check("arst outReady", int'(outReady), 1);
        check("arst hostOutValid", int'(hostOutValid), 0);
        check("arst hostOutData", int'(hostOutData), 0);
        @(posedge clock);
        #1 reset = 1'b1;
        model_reset();
        drive(1, 5, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 1, 0, 0, 0, 0);
        cycle();
        check("arst readback inAck", int'(inAck), 1);
        check("arst readback inHit", int'(inHit), 1);
        check("arst readback inData", int'(inData), 5);
        check_model("arst readback");
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();

        // random traffic against the model
        for (int i = 0; i < 800; i++) begin
            drive(bit'($urandom % 2), int'($urandom % 4096), bit'(($urandom % 3) == 0),
                  bit'($urandom % 2), int'($urandom % 4096), bit'(($urandom % 3) != 0),
                  bit'(($urandom % 50) == 0));
            cycle();
            check_model($sformatf("rnd%0d", i));
        end

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
